uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- UART transmitter: 8 data bits, 1 start bit, 1 stop bit, no parity, LSB first.
- It is the transmit-side counterpart of the team's UART receiver and uses the same CLKS_PER_BIT convention.
- Bytes are pushed through a small internal FIFO. The host can therefore queue bursts while a frame is on the line.
- Sits between the co-processor result path and the FPGA TX pin.

Parameters:
- CLKS_PER_BIT, 87: i_Clock cycles per UART bit (clock freq / baud). Legal range is 2 or more.
- FIFO_DEPTH, 4: number of queued bytes. Must be a power of 2 and at least 2.

Ports:
- i_Clock  input  1  system clock. All logic is on the rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Tx_DV  input  1  write strobe. A byte is accepted on any edge where i_Tx_DV=1 and o_Tx_Ready=1.
- i_Tx_Byte  input  8  byte to queue. Sampled only on an accepted write.
- o_Tx_Ready  output  1  FIFO not full (registered).
- o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.
- o_Tx_Serial  output  1  serial line (registered). Idles high.
- o_Tx_Active  output  1  high while a frame is on the line.
- o_Tx_Done  output  1  one-cycle pulse after each frame's stop bit.

Behaviour:
- Reset (any edge with i_Reset=1, including mid-frame):
  - FIFO emptied; o_Fifo_Count=0; o_Tx_Ready=1.
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0.
  - State returns to IDLE; bit index and clock counter are cleared.
  - A partial frame is abandoned. The line is high from the cycle after the reset edge.
- FIFO rules:
  - Circular buffer with read/write pointers and a count register.
  - A write while o_Tx_Ready=0 is dropped silently, with no state change. This holds even if a pop occurs on the same edge, because Ready is registered.
  - Push and pop on the same edge: both happen and the count is unchanged.
  - o_Tx_Ready = (count != FIFO_DEPTH), updated with count.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE:
    - o_Tx_Serial=1, o_Tx_Active=0, clock counter=0, bit index=0.
    - If count>0, pop the head into the shift register and go to START.
  - START:
    - o_Tx_Serial=0 and o_Tx_Active=1 for exactly CLKS_PER_BIT cycles, then go to DATA.
  - DATA:
    - o_Tx_Serial = shift[bit index], held CLKS_PER_BIT cycles per bit.
    - Bit index 0..7. After bit 7, go to STOP.
  - STOP:
    - o_Tx_Serial=1 for CLKS_PER_BIT cycles, then go to CLEANUP.
  - CLEANUP:
    - Lasts 1 cycle. o_Tx_Done=1, o_Tx_Active=0, o_Tx_Serial=1. Then go to IDLE.
  - Illegal state encoding: go to IDLE on the next edge.
- Timing:
  - Write to an empty FIFO while IDLE at edge E: o_Fifo_Count=1 after E. The pop happens at E+1, and o_Tx_Serial first reads 0 after E+2.
  - Frame length on the line is 10*CLKS_PER_BIT cycles (start + 8 data + stop).
  - Back-to-back queued bytes: the line is high for CLKS_PER_BIT+2 cycles between frames (stop bit, CLEANUP, IDLE).
- Widths:
  - Clock counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - Bit index is 3 bits.
  - No arithmetic overflow is reachable in legal configurations.
- i_Tx_Byte changes after acceptance do not affect queued or in-flight data.

Test Plan:
1. Single byte. CLKS_PER_BIT=4; write 0xA5 once. Required response:
   - o_Tx_Serial falls 2 edges after the write.
   - Line sequence, each level held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
   - o_Tx_Done pulses exactly once, 1 cycle after the stop bit.
   - o_Tx_Active is high for exactly 40 cycles.
2. Burst to full. CLKS_PER_BIT=4, FIFO_DEPTH=4; write 0x01..0x06 on consecutive edges. Required response:
   - 0x01 is popped on the second write's edge, so its write is a simultaneous push/pop.
   - 0x02..0x05 fill the FIFO: o_Fifo_Count reaches 4 and o_Tx_Ready=0.
   - 0x06 is dropped.
   - The line carries exactly 0x01..0x05 in order, with 6 high cycles between frames.
   - o_Tx_Done pulses 5 times.
3. Simultaneous push/pop. With count=1, write a byte on the same edge IDLE pops. Required response: o_Fifo_Count stays 1 and both bytes are transmitted in order.
4. Reset mid-frame. Assert i_Reset for 1 cycle during data bit 3 of a frame with 2 bytes queued. Required response:
   - Next cycle: o_Tx_Serial=1, o_Fifo_Count=0, o_Tx_Ready=1, o_Tx_Active=0.
   - No o_Tx_Done pulse and no further frames.
5. Loopback. CLKS_PER_BIT=87; connect o_Tx_Serial to the team UART receiver and send 0x00, 0xFF, 0x55, 0x80. Required response: the receiver outputs the same 4 bytes with one DV per byte, and o_Tx_Done count = 4.
6. Idle integrity. 1000 cycles with no writes after reset. Required response: o_Tx_Serial is constant 1, and o_Tx_Active and o_Tx_Done stay 0.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write handshake and serial-line status of uart_tx_fifo
// i_Tx_DV/i_Tx_Byte: write strobe and byte; o_Tx_Ready: FIFO not full; o_Fifo_Count: queued bytes
// o_Tx_Serial: UART line; o_Tx_Active: frame on the line; o_Tx_Done: end-of-frame pulse
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 4
) ();
    logic                        i_Tx_DV;
    logic [7:0]                  i_Tx_Byte;
    logic                        o_Tx_Ready;
    logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count;
    logic                        o_Tx_Serial;
    logic                        o_Tx_Active;
    logic                        o_Tx_Done;
    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Fifo_Count, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );
    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Fifo_Count, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 LSB-first UART transmitter fed by a small circular FIFO
// i_Clock: rising-edge clock; i_Reset: synchronous active-high reset
// bus (slave): write strobe/byte in; ready, queue count, serial line, active, done pulse out
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input logic           i_Clock,
    input logic           i_Reset,
    uart_tx_fifo_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] count_q, count_d;
    logic          ready_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          push, pop, bit_end, timing;

    // Ready is registered, so a write arriving while full is dropped even if IDLE pops on that edge.
    assign push    = bus.i_Tx_DV && ready_q;
    assign pop     = (state_q == IDLE) && (count_q != '0);
    assign count_d = count_q + NW'(push) - NW'(pop);
    assign bit_end = clk_cnt_q == LAST;
    assign timing  = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    // Line outputs are registered from the current state, so the line lags the state by one cycle.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        clk_cnt_d = (timing && !bit_end) ? clk_cnt_q + 1'b1 : '0;
        serial_d  = 1'b1;
        active_d  = timing;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                state_d   = pop ? START : IDLE;
            end
            START: begin
                serial_d = 1'b0;
                state_d  = bit_end ? DATA : START;
            end
            DATA: begin
                serial_d  = shift_q[bit_idx_q];
                bit_idx_d = bit_end ? bit_idx_q + 3'd1 : bit_idx_q;
                state_d   = (bit_end && bit_idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: state_d = bit_end ? CLEANUP : STOP;
            CLEANUP: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                bit_idx_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
            count_q   <= count_d;
            ready_q   <= count_d != NW'(FIFO_DEPTH);
            if (push) begin
                mem_q[wr_ptr_q] <= bus.i_Tx_Byte;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                shift_q  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign bus.o_Tx_Ready   = ready_q;
    assign bus.o_Fifo_Count = count_q;
    assign bus.o_Tx_Serial  = serial_q;
    assign bus.o_Tx_Active  = active_q;
    assign bus.o_Tx_Done    = done_q;
endmodule
